// File: rtl/rotary_input_if.sv
// rotary_input_if: encoder-side and paddle-side signals of the rotary front-end.
//   enable       : 1 = detents may produce events
//   rot_a, rot_b : raw quadrature pins (asynchronous)
//   rotary_event : one-cycle pulse per accepted detent
//   rotary_right : direction of the last event (1 = right)
//   speed        : step size, valid with rotary_event
// master = stimulus/encoder side, slave = rotary_input.
interface rotary_input_if;
  logic       enable;
  logic       rot_a;
  logic       rot_b;
  logic       rotary_event;
  logic       rotary_right;
  logic [4:0] speed;

  modport master (
    output enable, rot_a, rot_b,
    input  rotary_event, rotary_right, speed
  );

  modport slave (
    input  enable, rot_a, rot_b,
    output rotary_event, rotary_right, speed
  );
endinterface

// File: rtl/rotary_input.sv
// rotary_input: synchronises and debounces the encoder's A/B pins, decodes one
// detent into a single-cycle event with direction, and tracks an
// acceleration-based speed.
//   clock : system clock, rising edge
//   reset : synchronous, active low
//   bus   : rotary_input_if.slave (enable, rot_a, rot_b in;
//           rotary_event, rotary_right, speed out)

// Per-pin two-flop synchroniser plus debounce filter.
//   raw  : asynchronous pin
//   filt : value after DEBOUNCE_CYCLES consecutive stable cycles
module rotary_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filt
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      // any cycle where s2 agrees with filt restarts the stability window
      if (s2 == filt)
        cnt <= '0;
      else if (cnt == CNT_LAST) begin
        filt <= s2;
        cnt  <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
  end
endmodule

module rotary_input #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int FAST_GAP        = 2_500_000,
  parameter int SLOW_GAP        = 10_000_000,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_STEP      = 2,
  parameter int SPEED_MAX       = 24
) (
  input  logic           clock,
  input  logic           reset,
  rotary_input_if.slave  bus
);
  localparam int ARM_CYCLES = 2*DEBOUNCE_CYCLES + 4;
  localparam int AW = $clog2(ARM_CYCLES + 1);
  localparam int GW = $clog2(SLOW_GAP + 1);

  localparam logic [AW-1:0] ARM_LAST  = AW'(ARM_CYCLES - 1);
  localparam logic [GW-1:0] GAP_SLOW  = GW'(SLOW_GAP);
  localparam logic [GW-1:0] GAP_FAST  = GW'(FAST_GAP);
  localparam logic [GW-1:0] GAP_DECAY = GW'(SLOW_GAP - 1);
  localparam logic [4:0]    SPD_MIN   = 5'(SPEED_MIN);
  localparam logic [4:0]    SPD_MAX   = 5'(SPEED_MAX);
  localparam logic [5:0]    SPD_STEP6 = 6'(SPEED_STEP);
  localparam logic [5:0]    SPD_MAX6  = 6'(SPEED_MAX);

  // bit 0 = A, bit 1 = B
  logic [1:0] raw, filt;
  assign raw = {bus.rot_b, bus.rot_a};

  rotary_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb [1:0] (
    .clock (clock),
    .reset (reset),
    .raw   (raw),
    .filt  (filt)
  );

  logic fa, fb;
  assign fa = filt[0];
  assign fb = filt[1];

  // q1 tracks the last "corner" (11 vs 00); q2 the last mixed state
  // (01 -> 1, 10 -> 0). A q1 rise is one detent, q2 then gives direction.
  logic q1, q2, q1_d;

  always_ff @(posedge clock) begin
    if (!reset) begin
      q1   <= 1'b0;
      q2   <= 1'b0;
      q1_d <= 1'b0;
    end else begin
      if (fa & fb)        q1 <= 1'b1;
      else if (~fa & ~fb) q1 <= 1'b0;
      if (~fa & fb)       q2 <= 1'b1;
      else if (fa & ~fb)  q2 <= 1'b0;
      q1_d <= q1;
    end
  end

  // Startup arming: ignore the detent produced while the filters settle on
  // whatever level the encoder rests at.
  logic [AW-1:0] arm_cnt;
  logic          armed;

  always_ff @(posedge clock) begin
    if (!reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == ARM_LAST) armed   <= 1'b1;
      else                     arm_cnt <= arm_cnt + AW'(1);
    end
  end

  logic detent, fire, dir_right;
  assign detent    = q1 & ~q1_d;
  assign dir_right = ~q2;
  assign fire      = detent & bus.enable & armed;

  logic          ev_q, right_q, prev_right;
  logic [4:0]    speed_q, spd_next;
  logic [5:0]    spd_sum;
  logic [GW-1:0] gap;

  // Speed for an emitted event; gap is the value before it is cleared.
  always_comb begin
    spd_sum  = {1'b0, speed_q} + SPD_STEP6;
    spd_next = speed_q;
    if ((dir_right != prev_right) || (gap >= GAP_SLOW))
      spd_next = SPD_MIN;
    else if (gap < GAP_FAST)
      spd_next = (spd_sum > SPD_MAX6) ? SPD_MAX : spd_sum[4:0];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ev_q       <= 1'b0;
      right_q    <= 1'b0;
      prev_right <= 1'b1;
      speed_q    <= SPD_MIN;
      gap        <= GAP_SLOW;
    end else begin
      ev_q <= fire;
      if (fire) begin
        right_q    <= dir_right;
        prev_right <= dir_right;
        speed_q    <= spd_next;
        gap        <= '0;
      end else begin
        if (gap != GAP_SLOW) gap <= gap + GW'(1);
        // idle decay lands on the edge the counter reaches SLOW_GAP
        if (gap == GAP_DECAY) speed_q <= SPD_MIN;
      end
    end
  end

  assign bus.rotary_event = ev_q;
  assign bus.rotary_right = right_q;
  assign bus.speed        = speed_q;
endmodule

// File: tb/tb_rotary_input.sv
// tb_rotary_input: drives quadrature detents (fixed and $urandom timing) and
// compares pulses, direction and speed against a behavioural encoder model.
module tb_rotary_input;
  localparam int DC    = 4;
  localparam int FAST  = 100;
  localparam int SLOW  = 400;
  localparam int SMIN  = 2;
  localparam int SSTEP = 2;
  localparam int SMAX  = 24;
  localparam int ARM   = 2*DC + 4;
  localparam int LAT   = DC + 4;   // raw change to event pulse

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  rotary_input_if bus();

  rotary_input #(
    .DEBOUNCE_CYCLES(DC), .FAST_GAP(FAST), .SLOW_GAP(SLOW),
    .SPEED_MIN(SMIN), .SPEED_STEP(SSTEP), .SPEED_MAX(SMAX)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int t; int r; int s; } ev_t;
  ev_t act_q[$];
  ev_t exp_q[$];
  int  act_rd = 0, exp_rd = 0;
  int  n_chk = 0, n_fail = 0;

  always @(negedge clock)
    if (bus.rotary_event === 1'b1)
      act_q.push_back('{cyc, int'(bus.rotary_right), int'(bus.speed)});

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Encoder semantics: a detent is reaching 11 after the last corner was 00;
  // its direction is right if the last mixed state seen was 10.
  bit m_corner_hi, m_mix_right, m_prev_right, m_has_evt, m_en, m_out_right;
  int m_speed, m_last_evt, m_arm_time;

  task automatic model_reset(input int rel);
    m_corner_hi  = 0;
    m_mix_right  = 1;
    m_prev_right = 1;
    m_out_right  = 0;
    m_has_evt    = 0;
    m_speed      = SMIN;
    m_arm_time   = rel + ARM;
  endtask

  task automatic model_phase(input bit a, input bit b, input int t);
    int x, g;
    bit r;
    if (a && b) begin
      if (!m_corner_hi) begin
        x = t + LAT;
        r = m_mix_right;
        if (m_en && x > m_arm_time) begin
          // cycles counted since the previous event, seen before clearing
          g = m_has_evt ? x - m_last_evt - 1 : SLOW;
          if (g > SLOW) g = SLOW;
          if (r != m_prev_right || g >= SLOW) m_speed = SMIN;
          else if (g < FAST) m_speed = (m_speed + SSTEP > SMAX) ? SMAX : m_speed + SSTEP;
          m_prev_right = r;
          m_out_right  = r;
          m_last_evt   = x;
          m_has_evt    = 1;
          exp_q.push_back('{x, int'(r), m_speed});
        end
      end
      m_corner_hi = 1;
    end else if (!a && !b) m_corner_hi = 0;
    else m_mix_right = a;
  endtask

  function automatic int exp_speed(input int c);
    if (m_has_evt && (c - m_last_evt >= SLOW)) return SMIN;
    return m_speed;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic phase(input bit a, input bit b, input int hold);
    bus.rot_a = a;
    bus.rot_b = b;
    model_phase(a, b, cyc);
    wait_cycles(hold);
  endtask

  task automatic detent(input bit right, input int h0, input int h1, input int h2);
    phase(1'b0, 1'b0, h0);
    phase(right, ~right, h1);
    phase(1'b1, 1'b1, h2);
  endtask

  task automatic cmp_events(input string tag);
    int na, ne, n;
    na = act_q.size() - act_rd;
    ne = exp_q.size() - exp_rd;
    chk({tag, "_count"}, na, ne);
    n = (na < ne) ? na : ne;
    for (int i = 0; i < n; i++) begin
      chk({tag, "_time"},  act_q[act_rd+i].t, exp_q[exp_rd+i].t);
      chk({tag, "_right"}, act_q[act_rd+i].r, exp_q[exp_rd+i].r);
      chk({tag, "_speed"}, act_q[act_rd+i].s, exp_q[exp_rd+i].s);
    end
    act_rd = act_q.size();
    exp_rd = exp_q.size();
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_speed"}, int'(bus.speed), exp_speed(cyc));
    chk({tag, "_right"}, int'(bus.rotary_right), int'(m_out_right));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.enable = 1'b1;
    bus.rot_a  = 1'b1;
    bus.rot_b  = 1'b1;
    reset      = 1'b0;
    m_en       = 1;
    model_reset(0);
    wait_cycles(3);

    // reset values
    chk("rst_event", int'(bus.rotary_event), 0);
    chk("rst_right", int'(bus.rotary_right), 0);
    chk("rst_speed", int'(bus.speed), SMIN);

    // 1: encoder resting at 11 through startup gives no event
    reset = 1'b1;
    model_reset(cyc);
    model_phase(1'b1, 1'b1, cyc);
    wait_cycles(50);
    cmp_events("t1");
    chk_outputs("t1");

    // 2: left detent 00 -> 01 -> 11
    phase(1'b0, 1'b0, 10);
    phase(1'b0, 1'b1, 10);
    phase(1'b1, 1'b1, 10);
    cmp_events("t2");
    chk_outputs("t2");

    // 3: 15 fast right detents, speed ramps then saturates
    for (int i = 0; i < 15; i++) detent(1'b1, 13, 13, 14);
    cmp_events("t3");
    chk("t3_sat", int'(bus.speed), SMAX);

    // 4: 3-cycle glitch on A with B=1 must not reach the filter
    bus.rot_a = 1'b0;
    wait_cycles(3);
    bus.rot_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t4_filt", int'(dut.filt), 3);
      wait_cycles(1);
    end
    cmp_events("t4");

    // 5: idle decay, ramp to 10, reversal, ramp again, exact decay edge
    while (cyc < m_last_evt + SLOW + 20) wait_cycles(1);
    chk("t5_decay", int'(bus.speed), SMIN);
    for (int i = 0; i < 5; i++) detent(1'b1, 10, 10, 10);
    chk_outputs("t5_ramp");
    detent(1'b0, 10, 10, 10);
    chk_outputs("t5_rev");
    for (int i = 0; i < 5; i++) detent(1'b1, 10, 10, 10);
    cmp_events("t5");
    chk("t5_at10", int'(bus.speed), 10);
    while (cyc < m_last_evt + SLOW - 1) wait_cycles(1);
    chk("t5_hold", int'(bus.speed), exp_speed(cyc));
    wait_cycles(1);
    chk("t5_idle", int'(bus.speed), exp_speed(cyc));
    chk("t5_idle_min", int'(bus.speed), SMIN);

    // randomised detents: direction, phase holds and idle gaps
    for (int i = 0; i < 25; i++) begin
      detent(1'($urandom_range(0, 1)), int'($urandom_range(6, 40)),
             int'($urandom_range(6, 40)), int'($urandom_range(6, 40)));
      if ($urandom_range(0, 5) == 0) wait_cycles(int'($urandom_range(100, 450)));
    end
    wait_cycles(10);
    cmp_events("rnd");
    chk_outputs("rnd");

    // 6a: detents while disabled are dropped
    bus.enable = 1'b0;
    m_en = 0;
    for (int i = 0; i < 3; i++) detent(1'b1, 10, 10, 10);
    bus.enable = 1'b1;
    m_en = 1;
    detent(1'b1, 10, 10, 10);
    cmp_events("t6_en");
    chk_outputs("t6_en");

    // 6b: reset on the cycle before a pulse is due
    phase(1'b0, 1'b0, 10);
    phase(1'b1, 1'b0, 10);
    bus.rot_a = 1'b1;
    bus.rot_b = 1'b1;
    n = cyc;
    model_phase(1'b1, 1'b1, n);
    wait_cycles(LAT - 2);
    reset = 1'b0;
    while (exp_q.size() > exp_rd && exp_q[exp_q.size()-1].t >= n + LAT - 1)
      void'(exp_q.pop_back());
    wait_cycles(3);
    chk("t6_rst_event", int'(bus.rotary_event), 0);
    chk("t6_rst_right", int'(bus.rotary_right), 0);
    chk("t6_rst_speed", int'(bus.speed), SMIN);
    reset = 1'b1;
    model_reset(cyc);
    model_phase(1'b1, 1'b1, cyc);
    wait_cycles(30);
    cmp_events("t6_rst");
    detent(1'b0, 10, 10, 10);
    detent(1'b1, 10, 10, 10);
    cmp_events("t6_post");
    chk_outputs("t6_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
